// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: shared constants for the bus timer.
//   Register offsets (word index from Addr[3:2]), CTRL bit positions,
//   mode encodings and the 2-bit FSM state encoding.
package timer_dev_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_dev_if.sv
// timer_dev_if: processor-bus connection of the timer.
//   Addr/DIn/Wen : bus address, write data, write enable (from CPU bridge)
//   DOut         : read data back to the CPU (combinational in the device)
//   IRQ          : interrupt line into one HWInt bit
interface timer_dev_if;
    logic [31:0] Addr;
    logic [31:0] DIn;
    logic        Wen;
    logic [31:0] DOut;
    logic        IRQ;

    modport master (output Addr, output DIn, output Wen, input DOut, input IRQ);
    modport slave  (input Addr, input DIn, input Wen, output DOut, output IRQ);
endinterface

// File: rtl/timer_dev_fsm.sv
// timer_fsm: counting engine of the timer (state, COUNT, pending bit, IRQ).
//   clk, rst   : clock, synchronous active-low reset
//   en, mode   : current CTRL.En / CTRL.Mode
//   im_next    : CTRL.IM as it will be after this edge (IRQ tracks pend & IM)
//   ctrl_wr    : CTRL is being written this cycle (clears pend)
//   preset     : reload value
//   count      : current COUNT
//   pend, irq  : pending bit and registered interrupt
//   en_clr     : request to drop CTRL.En (one-shot expiry), combinational
module timer_fsm
    import timer_dev_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic        im_next,
    input  logic        ctrl_wr,
    input  logic [31:0] preset,
    output logic [31:0] count,
    output logic        pend,
    output logic        irq,
    output logic        en_clr
);

    state_t state;
    logic   reload;
    logic   pend_auto;   // pend was raised by an auto-reload expiry; drop it next edge
    logic   pend_next;

    // Modes 2 and 3 fall back to one-shot.
    always_comb begin
        reload = 1'b0;
        case (mode)
            MODE_RELOAD:  reload = 1'b1;
            MODE_ONESHOT: reload = 1'b0;
            default:      reload = 1'b0;
        endcase
    end

    assign en_clr = (state == ST_INT) && !reload;

    // Expiry set has priority over the CTRL-write clear.
    always_comb begin
        pend_next = pend;
        if (state == ST_INT)
            pend_next = 1'b1;
        else if (ctrl_wr || pend_auto)
            pend_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            pend      <= 1'b0;
            pend_auto <= 1'b0;
            irq       <= 1'b0;
        end else begin
            pend      <= pend_next;
            irq       <= pend_next & im_next;
            pend_auto <= (state == ST_INT) && reload;
            case (state)
                ST_IDLE: if (en) state <= ST_LOAD;
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en)
                        state <= ST_IDLE;
                    else if (count > 32'd1)
                        count <= count - 32'd1;
                    else begin
                        // PRESET of 0 lands here too, so it behaves as 1.
                        count <= '0;
                        state <= ST_INT;
                    end
                end
                ST_INT:  state <= reload ? ST_LOAD : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/timer_dev.sv
// timer_dev: programmable down-counting timer on the processor bus.
//   clk, rst : clock, synchronous active-low reset
//   bus      : timer_dev_if.slave (Addr, DIn, Wen in; DOut, IRQ out)
//   Map (Addr[3:2]): 0 CTRL {IM, Mode[1:0], En}, 1 PRESET, 2 COUNT (RO), 3 reserved.
//   CTRL reads back as {27'b0, pend, CTRL}.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst,
    timer_dev_if.slave  bus
);

    logic        hit;
    logic [1:0]  off;
    logic        ctrl_wr;
    logic        preset_wr;
    logic [3:0]  ctrl, ctrl_next;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pend;
    logic        en_clr;
    logic        unused_addr;

    assign hit         = (bus.Addr[31:4] == BASE_ADDR[31:4]);
    assign off         = bus.Addr[3:2];
    assign unused_addr = ^bus.Addr[1:0];
    assign ctrl_wr     = bus.Wen && hit && (off == OFF_CTRL);
    assign preset_wr   = bus.Wen && hit && (off == OFF_PRESET);

    // A CTRL write in the expiry cycle wins over the one-shot En clear.
    always_comb begin
        ctrl_next = ctrl;
        if (ctrl_wr)
            ctrl_next = bus.DIn[3:0];
        else if (en_clr)
            ctrl_next[CTRL_EN] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl   <= '0;
            preset <= '0;
        end else begin
            ctrl <= ctrl_next;
            if (preset_wr)
                preset <= bus.DIn;
        end
    end

    timer_fsm u_fsm (
        .clk     (clk),
        .rst     (rst),
        .en      (ctrl[CTRL_EN]),
        .mode    (ctrl[CTRL_MODE_LSB +: 2]),
        .im_next (ctrl_next[CTRL_IM]),
        .ctrl_wr (ctrl_wr),
        .preset  (preset),
        .count   (count),
        .pend    (pend),
        .irq     (bus.IRQ),
        .en_clr  (en_clr)
    );

    always_comb begin
        bus.DOut = '0;
        if (hit) begin
            case (off)
                OFF_CTRL:   bus.DOut = {27'b0, pend, ctrl};
                OFF_PRESET: bus.DOut = preset;
                OFF_COUNT:  bus.DOut = count;
                default:    bus.DOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scoreboard bench for timer_dev. Each bus cycle queues the
// expected DOut/IRQ; a negedge monitor pops and compares them.
module tb_timer_dev;

    localparam logic [31:0] A_CTRL = 32'h0000_7F00;
    localparam logic [31:0] A_PRE  = 32'h0000_7F04;
    localparam logic [31:0] A_CNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSV  = 32'h0000_7F0C;
    localparam logic [31:0] A_MISS = 32'h0000_7F10;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          is_irq;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    sb_t  sb_q[$];

    timer_dev_if bus ();

    timer_dev dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            if (e.is_irq) chk(e.tag, {31'b0, bus.IRQ}, e.exp);
            else          chk(e.tag, bus.DOut, e.exp);
        end
    end

    // One bus cycle: drive, queue expectations for this cycle, advance past the edge.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [31:0] ed, input logic ei, input string tag);
        sb_t e;
        bus.Addr = a;
        bus.DIn  = d;
        bus.Wen  = w;
        e.tag = {tag, " dout"}; e.exp = ed; e.is_irq = 1'b0; sb_q.push_back(e);
        e.tag = {tag, " irq"};  e.exp = {31'b0, ei}; e.is_irq = 1'b1; sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.Wen = 1'b0;
    endtask

    task automatic do_reset();
        bus.Wen = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Auto-reload COUNT pattern for PRESET=2, phase 0 = cycle after LOAD.
    function automatic logic [31:0] rl2(input int m);
        case (m % 4)
            0:       return 32'd2;
            1:       return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        bus.Addr = '0;
        bus.DIn  = '0;
        bus.Wen  = 1'b0;

        // 1: reset state
        do_reset();
        cyc(A_CTRL, 0, 0, 0, 0, "t1 ctrl");
        cyc(A_PRE,  0, 0, 0, 0, "t1 pre");
        cyc(A_CNT,  0, 0, 0, 0, "t1 cnt");

        // 2: one-shot, PRESET=3, IRQ at write edge + 6
        do_reset();
        cyc(A_PRE,  3, 1, 0, 0, "t2 wr pre");
        cyc(A_CTRL, 9, 1, 0, 0, "t2 wr ctrl");
        for (int k = 0; k < 8; k++)
            cyc(A_CNT, 0, 0, (k < 2) ? 32'd0 : (k <= 5 ? 32'(5 - k) : 32'd0),
                k >= 6, $sformatf("t2 k%0d", k));
        cyc(A_CTRL, 0, 0, 32'h18, 1, "t2 ctrl done");
        cyc(A_CTRL, 0, 1, 32'h18, 1, "t2 wr clr");
        cyc(A_CTRL, 0, 0, 32'h00, 0, "t2 after clr");

        // 3: auto-reload, PRESET=2, pulse period 4
        do_reset();
        cyc(A_PRE,  2,     1, 0, 0, "t3 wr pre");
        cyc(A_CTRL, 32'hB, 1, 0, 0, "t3 wr ctrl");
        for (int k = 0; k < 17; k++)
            cyc(A_CNT, 0, 0, (k < 2) ? 32'd0 : rl2(k - 2),
                (k >= 5) && ((k - 5) % 4 == 0), $sformatf("t3 k%0d", k));
        cyc(A_CTRL, 0, 1, 32'h1B, 1, "t3 wr off");
        cyc(A_CTRL, 0, 0, 32'h00, 0, "t3 off");

        // 4: PRESET=0 acts as 1; masked pend; re-enable clears pend
        do_reset();
        cyc(A_PRE,  0, 1, 0, 0, "t4 wr pre");
        cyc(A_CTRL, 1, 1, 0, 0, "t4 wr ctrl");
        for (int k = 0; k < 7; k++)
            cyc(A_CTRL, 0, 0, (k < 4) ? 32'h01 : 32'h10, 0, $sformatf("t4a k%0d", k));
        cyc(A_CTRL, 9, 1, 32'h10, 0, "t4 wr ctrl9");
        for (int k = 0; k < 6; k++)
            cyc(A_CTRL, 0, 0, (k < 4) ? 32'h09 : 32'h18, k >= 4, $sformatf("t4b k%0d", k));

        // 5a: PRESET rewritten mid-count; applies at next reload
        do_reset();
        cyc(A_PRE,  10, 1, 0, 0, "t5 wr pre");
        cyc(A_CTRL, 3,  1, 0, 0, "t5 wr ctrl");
        for (int k = 0; k < 5; k++)
            cyc(A_CNT, 0, 0, (k < 2) ? 32'd0 : 32'(12 - k), 0, $sformatf("t5a k%0d", k));
        cyc(A_PRE, 2, 1, 32'd10, 0, "t5a wr pre2");
        for (int k = 6; k < 20; k++)
            cyc(A_CNT, 0, 0, (k <= 12) ? 32'(12 - k) : (k == 13 ? 32'd0 : rl2(k - 14)),
                0, $sformatf("t5a k%0d", k));
        // CTRL write lands on the INT edge: pend set, written En=0 kept
        cyc(A_CTRL, 0, 1, 32'h03, 0, "t5a wr int");
        cyc(A_CTRL, 0, 0, 32'h10, 0, "t5a pend pulse");
        cyc(A_CTRL, 0, 0, 32'h00, 0, "t5a pend gone");

        // 5b: clear En so COUNT freezes at 4, then re-enable reloads
        do_reset();
        cyc(A_PRE,  10, 1, 0, 0, "t5b wr pre");
        cyc(A_CTRL, 1,  1, 0, 0, "t5b wr ctrl");
        for (int k = 0; k < 7; k++)
            cyc(A_CNT, 0, 0, (k < 2) ? 32'd0 : 32'(12 - k), 0, $sformatf("t5b k%0d", k));
        cyc(A_CTRL, 0, 1, 32'h01, 0, "t5b wr dis");
        for (int k = 8; k < 12; k++)
            cyc(A_CNT, 0, 0, 32'd4, 0, $sformatf("t5b hold k%0d", k));
        cyc(A_CTRL, 1, 1, 32'h00, 0, "t5b wr reen");
        cyc(A_CNT, 0, 0, 32'd4,  0, "t5b reen k0");
        cyc(A_CNT, 0, 0, 32'd4,  0, "t5b reen k1");
        cyc(A_CNT, 0, 0, 32'd10, 0, "t5b reen k2");

        // 6a: decode - misses and read-only/reserved writes change nothing
        do_reset();
        cyc(A_PRE,        5,            1, 0,    0, "t6 wr pre");
        cyc(A_MISS,       32'hFFFF_FFFF, 1, 0,   0, "t6 wr miss");
        cyc(32'h0000_8F00, 32'hF,       1, 0,    0, "t6 wr alias");
        cyc(A_CNT,        32'hFFFF_FFFF, 1, 0,   0, "t6 wr cnt");
        cyc(A_RSV,        32'hF,        1, 0,    0, "t6 wr rsv");
        cyc(A_CTRL,       0, 0, 32'h0, 0, "t6 rd ctrl");
        cyc(32'h0000_7F07, 0, 0, 32'd5, 0, "t6 rd pre lowbits");
        cyc(A_CNT,        0, 0, 32'd0, 0, "t6 rd cnt");
        cyc(A_MISS + 4,   0, 0, 32'd0, 0, "t6 rd miss");

        // 6b: CTRL write in the one-shot INT cycle
        do_reset();
        cyc(A_PRE,  1, 1, 0, 0, "t6b wr pre");
        cyc(A_CTRL, 1, 1, 0, 0, "t6b wr ctrl");
        cyc(A_CNT, 0, 0, 0, 0, "t6b k0");
        cyc(A_CNT, 0, 0, 0, 0, "t6b k1");
        cyc(A_CNT, 0, 0, 1, 0, "t6b k2");
        cyc(A_CTRL, 9, 1, 32'h01, 0, "t6b wr int");
        cyc(A_CTRL, 0, 0, 32'h19, 1, "t6b after");

        // 6c: reset mid-count with a simultaneous write
        do_reset();
        cyc(A_PRE,  5,     1, 0, 0, "t6c wr pre");
        cyc(A_CTRL, 32'hB, 1, 0, 0, "t6c wr ctrl");
        cyc(A_CNT, 0, 0, 0, 0, "t6c k0");
        cyc(A_CNT, 0, 0, 0, 0, "t6c k1");
        cyc(A_CNT, 0, 0, 5, 0, "t6c k2");
        cyc(A_CNT, 0, 0, 4, 0, "t6c k3");
        rst = 1'b0;
        cyc(A_PRE, 7, 1, 32'd5, 0, "t6c rst+wr");
        rst = 1'b1;
        cyc(A_CTRL, 0, 0, 0, 0, "t6c ctrl");
        cyc(A_PRE,  0, 0, 0, 0, "t6c pre");
        cyc(A_CNT,  0, 0, 0, 0, "t6c cnt");
        cyc(A_CNT,  0, 0, 0, 0, "t6c cnt idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
